// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer: operand width,
// M-extension funct3 codes, sequencer states and small operand helpers.
package div_ctrl_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] INST_DIV  = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM  = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_CALC  = 2'd2,
      ST_END   = 2'd3
   } div_state_t;

   function automatic logic is_div_op(input logic [2:0] funct3);
      return (funct3 inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU});
   endfunction

   // Unsigned view of an operand: negative signed values become their magnitude.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value,
                                                 input logic is_signed);
      return (is_signed && value[XLEN-1]) ? -value : value;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the
// divide sequencer (slave).
interface div_ctrl_if;

   logic                              start_i;
   logic [2:0]                        funct3_i;
   logic [div_ctrl_pkg::XLEN-1:0]     dividend_i;
   logic [div_ctrl_pkg::XLEN-1:0]     divisor_i;
   logic [4:0]                        rd_addr_i;
   logic                              flush_i;
   logic [div_ctrl_pkg::XLEN-1:0]     result_o;
   logic [4:0]                        rd_addr_o;
   logic                              rd_wen_o;
   logic                              ready_o;
   logic                              busy_o;
   logic                              hold_flag_o;

   modport master (
      output start_i, funct3_i, dividend_i, divisor_i, rd_addr_i, flush_i,
      input  result_o, rd_addr_o, rd_wen_o, ready_o, busy_o, hold_flag_o
   );

   modport slave (
      input  start_i, funct3_i, dividend_i, divisor_i, rd_addr_i, flush_i,
      output result_o, rd_addr_o, rd_wen_o, ready_o, busy_o, hold_flag_o
   );

endinterface

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while running and returns the result with a one-cycle write-back.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   div_ctrl_if.slave   bus
);

   div_state_t        state;
   logic [1:0]        op;
   logic [XLEN-1:0]   dividend_q;
   logic [XLEN-1:0]   divisor_q;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;
   logic              q_neg;
   logic              r_neg;
   logic [4:0]        rd_addr_q;
   logic [4:0]        count;

   logic              op_signed;
   logic              start_ok;
   logic              busy;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     trial;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   result_sel;

   assign op_signed = ~op[0];
   assign start_ok  = (state == ST_IDLE) & bus.start_i & is_div_op(bus.funct3_i);
   assign busy      = (state == ST_START) | (state == ST_CALC);

   // The partial remainder always stays below the divisor, so only the
   // shifted trial value needs the extra bit to expose the borrow.
   assign shifted    = {rem, quot[XLEN-1]};
   assign trial      = shifted - {1'b0, divisor_q};
   assign quot_fix   = q_neg ? -quot : quot;
   assign rem_fix    = r_neg ? -rem : rem;
   assign result_sel = op[1] ? rem_fix : quot_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         op         <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quot       <= '0;
         rem        <= '0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         rd_addr_q  <= '0;
         count      <= '0;
      end else if ((state != ST_IDLE) && bus.flush_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  op         <= bus.funct3_i[1:0];
                  rd_addr_q  <= bus.rd_addr_i;
                  dividend_q <= bus.dividend_i;
                  divisor_q  <= bus.divisor_i;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               count     <= '0;
               rem       <= '0;
               quot      <= magnitude(dividend_q, op_signed);
               divisor_q <= magnitude(divisor_q, op_signed);
               q_neg     <= op_signed & (dividend_q[XLEN-1] ^ divisor_q[XLEN-1]);
               r_neg     <= op_signed & dividend_q[XLEN-1];
               // Special cases load final values directly and skip the sign fix-up.
               if (divisor_q == '0) begin
                  quot  <= '1;
                  rem   <= dividend_q;
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
                  state <= ST_END;
               end else if (op_signed && (dividend_q == 32'h8000_0000) &&
                            (divisor_q == 32'hFFFF_FFFF)) begin
                  quot  <= 32'h8000_0000;
                  rem   <= '0;
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
                  state <= ST_END;
               end else begin
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (!trial[XLEN]) begin
                  rem  <= trial[XLEN-1:0];
                  quot <= {quot[XLEN-2:0], 1'b1};
               end else begin
                  rem  <= shifted[XLEN-1:0];
                  quot <= {quot[XLEN-2:0], 1'b0};
               end
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  state <= ST_END;
               end
            end
            ST_END: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.result_o    = (state == ST_END) ? result_sel : '0;
   assign bus.rd_addr_o   = rd_addr_q;
   assign bus.rd_wen_o    = (state == ST_END) & ~bus.flush_i;
   assign bus.ready_o     = (state == ST_END) & ~bus.flush_i;
   assign bus.busy_o      = busy;
   assign bus.hold_flag_o = start_ok | busy;

endmodule
